regfile_scoreboard: RTL and testbench

Parametrised integer register file for the RV32I core, generalising the original two-read/one-write array. It adds a configurable number of read ports and a synchronous reset that clears all registers. Register 0 is hardwired to zero. Same-cycle write-to-read bypass is selectable by parameter. A per-register pending-write scoreboard lets decode detect read-after-write hazards against in-flight instructions. It sits between decode (read/issue side) and writeback (write side).

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 69 ++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the integer register file with its
// pending-write scoreboard. The master side is decode plus writeback; the
// slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  issue_en;
  logic [AW-1:0]         issue_rd;
  logic [NREGS-1:0]      pending;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rd_data, rd_busy, pending
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rd_data, rd_busy, pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised RV32I integer register file: NREAD combinational read ports,
// one writeback port, optional same-cycle write-to-read bypass, x0 hardwired
// to zero, and a per-register pending-write scoreboard for RAW hazard checks.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  // Entry 0 is never stored; reads of x0 are forced to zero below.
  logic [XLEN-1:0]  regs_r [1:NREGS-1];
  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;

  // Writeback into the array; writes to x0 are dropped, reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else if (bus.wr_en && (bus.wr_addr != AW'(0))) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Decode issue and writeback strobes into per-register set/clear masks (x0 excluded).
  always_comb begin
    set_mask_s = {NREGS{1'b0}};
    clr_mask_s = {NREGS{1'b0}};
    for (int r = 1; r < NREGS; r++) begin
      set_mask_s[r] = bus.issue_en && (bus.issue_rd == AW'(r));
      clr_mask_s[r] = bus.wr_en && (bus.wr_addr == AW'(r));
    end
  end

  // Scoreboard: a same-cycle issue beats the retiring writeback, since the
  // writeback belongs to the older instruction; bit 0 is held at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NREGS{1'b0}};
    end else begin
      pending_r <= ((pending_r & ~clr_mask_s) | set_mask_s) & {{(NREGS-1){1'b1}}, 1'b0};
    end
  end

  assign bus.pending = pending_r;

  // Read ports: x0 reads zero, a bypass hit returns the incoming writeback
  // data and also hides busy, otherwise the stored value is returned.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr_s;
    logic          hit_s;

    assign addr_s = bus.rd_addr[i*AW +: AW];
    assign hit_s  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == addr_s);

    assign bus.rd_data[i*XLEN +: XLEN] = (addr_s == AW'(0)) ? {XLEN{1'b0}} :
                                         hit_s              ? bus.wr_data  :
                                                              regs_r[addr_s];
    assign bus.rd_busy[i] = pending_r[addr_s] && !hit_s;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard. Three configurations run side by
// side: A (32x32, 2 ports, bypass), B (32x32, 2 ports, no bypass) and
// C (16x64, 4 ports, bypass). Only one configuration is driven per cycle.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2)) if_a ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2)) if_b ();
  regfile_scoreboard_if #(.XLEN(64), .NREGS(16), .NREAD(4)) if_c ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  regfile_scoreboard #(.XLEN(64), .NREGS(16), .NREAD(4), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  int xlen_tab  [3] = '{32, 32, 64};
  int nregs_tab [3] = '{32, 32, 16};
  int nread_tab [3] = '{2, 2, 4};
  int byp_tab   [3] = '{1, 0, 1};

  // Reference model: architectural register values and outstanding writers.
  logic [63:0] m_regs [3][32];
  logic        m_pend [3][32];

  typedef struct {
    int              cfg;
    int              id;
    logic [3:0][63:0] data;
    logic [3:0]      busy;
    logic [31:0]     pend;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   step_id = 0;

  task automatic idle_all();
    if_a.wr_en = 1'b0; if_a.wr_addr = '0; if_a.wr_data = '0; if_a.issue_en = 1'b0; if_a.issue_rd = '0; if_a.rd_addr = '0;
    if_b.wr_en = 1'b0; if_b.wr_addr = '0; if_b.wr_data = '0; if_b.issue_en = 1'b0; if_b.issue_rd = '0; if_b.rd_addr = '0;
    if_c.wr_en = 1'b0; if_c.wr_addr = '0; if_c.wr_data = '0; if_c.issue_en = 1'b0; if_c.issue_rd = '0; if_c.rd_addr = '0;
  endtask

  // Apply one cycle of stimulus to configuration c, queue the expected
  // outputs for this cycle, then advance the model past the next edge.
  task automatic step(input int c, input logic r, input logic we, input int wa, input logic [63:0] wd,
                      input logic ie, input int ir, input int a0, input int a1, input int a2, input int a3);
    int          msk;
    int          a [4];
    int          wam;
    int          irm;
    logic [63:0] dm;
    logic [63:0] wdm;
    logic        hit;
    exp_t        e;
    msk  = nregs_tab[c] - 1;
    dm   = (xlen_tab[c] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a[0] = a0 & msk; a[1] = a1 & msk; a[2] = a2 & msk; a[3] = a3 & msk;
    wam  = wa & msk;
    irm  = ir & msk;
    wdm  = wd & dm;
    idle_all();
    rst = r;
    case (c)
      0: begin
        if_a.wr_en = we; if_a.wr_addr = wam[4:0]; if_a.wr_data = wdm[31:0];
        if_a.issue_en = ie; if_a.issue_rd = irm[4:0]; if_a.rd_addr = {a[1][4:0], a[0][4:0]};
      end
      1: begin
        if_b.wr_en = we; if_b.wr_addr = wam[4:0]; if_b.wr_data = wdm[31:0];
        if_b.issue_en = ie; if_b.issue_rd = irm[4:0]; if_b.rd_addr = {a[1][4:0], a[0][4:0]};
      end
      default: begin
        if_c.wr_en = we; if_c.wr_addr = wam[3:0]; if_c.wr_data = wdm;
        if_c.issue_en = ie; if_c.issue_rd = irm[3:0];
        if_c.rd_addr = {a[3][3:0], a[2][3:0], a[1][3:0], a[0][3:0]};
      end
    endcase

    e.cfg = c; e.id = step_id; e.data = '0; e.busy = '0; e.pend = '0;
    for (int i = 0; i < 4; i++) begin
      hit = (byp_tab[c] == 1) && we && (wam == a[i]);
      if (a[i] == 0)  e.data[i] = 64'h0;
      else if (hit)   e.data[i] = wdm;
      else            e.data[i] = m_regs[c][a[i]];
      e.busy[i] = (a[i] != 0) && m_pend[c][a[i]] && !hit;
    end
    for (int k = 0; k < nregs_tab[c]; k++) e.pend[k] = m_pend[c][k];
    exp_q.push_back(e);

    if (r) begin
      for (int cc = 0; cc < 3; cc++)
        for (int k = 0; k < 32; k++) begin
          m_regs[cc][k] = 64'h0;
          m_pend[cc][k] = 1'b0;
        end
    end else begin
      if (we && wam != 0) m_regs[c][wam] = wdm;
      if (we) m_pend[c][wam] = 1'b0;
      if (ie && irm != 0) m_pend[c][irm] = 1'b1;
    end
    step_id++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each falling edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t             e;
    logic [3:0][63:0] act_d;
    logic [3:0]       act_b;
    logic [31:0]      act_p;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_d = '0; act_b = '0; act_p = '0;
        case (e.cfg)
          0: begin
            for (int i = 0; i < 2; i++) begin
              act_d[i] = {32'h0, if_a.rd_data[i*32 +: 32]};
              act_b[i] = if_a.rd_busy[i];
            end
            act_p = if_a.pending;
          end
          1: begin
            for (int i = 0; i < 2; i++) begin
              act_d[i] = {32'h0, if_b.rd_data[i*32 +: 32]};
              act_b[i] = if_b.rd_busy[i];
            end
            act_p = if_b.pending;
          end
          default: begin
            for (int i = 0; i < 4; i++) begin
              act_d[i] = if_c.rd_data[i*64 +: 64];
              act_b[i] = if_c.rd_busy[i];
            end
            act_p = {16'h0, if_c.pending};
          end
        endcase
        for (int i = 0; i < nread_tab[e.cfg]; i++) begin
          checks++;
          if (act_d[i] !== e.data[i]) begin
            errors++;
            $display("FAIL cfg%0d step%0d rd_data%0d got=%h want=%h", e.cfg, e.id, i, act_d[i], e.data[i]);
          end
          checks++;
          if (act_b[i] !== e.busy[i]) begin
            errors++;
            $display("FAIL cfg%0d step%0d rd_busy%0d got=%b want=%b", e.cfg, e.id, i, act_b[i], e.busy[i]);
          end
        end
        checks++;
        if (act_p !== e.pend) begin
          errors++;
          $display("FAIL cfg%0d step%0d pending got=%h want=%h", e.cfg, e.id, act_p, e.pend);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic on each configuration.
  initial begin
    rst = 1'b1;
    idle_all();
    for (int cc = 0; cc < 3; cc++)
      for (int k = 0; k < 32; k++) begin
        m_regs[cc][k] = 64'h0;
        m_pend[cc][k] = 1'b0;
      end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then write x5 and clear it again with reset.
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 5, 5, 0, 0);
    step(0, 1'b0, 1'b1, 5, 64'hDEADBEEF, 1'b0, 0, 5, 5, 0, 0);
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b1, 6, 5, 5, 0, 0);
    step(0, 1'b1, 1'b1, 5, 64'h1111, 1'b1, 5, 5, 6, 0, 0);
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 5, 5, 0, 0);
    // x0 hardwiring: write and issue to x0.
    step(0, 1'b0, 1'b1, 0, 64'hFFFFFFFF, 1'b1, 0, 0, 0, 0, 0);
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 0, 0, 0, 0);
    // Bypass versus no bypass on x7.
    step(0, 1'b0, 1'b1, 7, 64'h12345678, 1'b0, 0, 0, 7, 0, 0);
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 7, 7, 0, 0);
    step(1, 1'b0, 1'b1, 7, 64'h12345678, 1'b0, 0, 0, 7, 0, 0);
    step(1, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 7, 7, 0, 0);
    // Scoreboard life cycle on x3 for both bypass settings.
    for (int c = 0; c < 2; c++) begin
      step(c, 1'b0, 1'b0, 0, 64'h0, 1'b1, 3, 3, 3, 0, 0);
      step(c, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 3, 3, 0, 0);
      step(c, 1'b0, 1'b1, 3, 64'hA5, 1'b0, 0, 3, 3, 0, 0);
      step(c, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 3, 3, 0, 0);
    end
    // Simultaneous set and clear on x9: data lands, pending stays set.
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b1, 9, 9, 0, 0, 0);
    step(0, 1'b0, 1'b1, 9, 64'h55, 1'b1, 9, 9, 9, 0, 0);
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 9, 9, 0, 0);
    step(0, 1'b0, 1'b1, 9, 64'h66, 1'b0, 0, 9, 0, 0, 0);
    // Mid-operation reset drops the in-flight writer; a late writeback only updates data.
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b1, 4, 4, 4, 0, 0);
    step(0, 1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 4, 4, 0, 0);
    step(0, 1'b0, 1'b1, 4, 64'hCAFE, 1'b0, 0, 4, 4, 0, 0);
    step(0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 4, 4, 0, 0);
    // Wide configuration: fill x1..x15 with distinct 64-bit values, then random reads.
    for (int k = 1; k < 16; k++)
      step(2, 1'b0, 1'b1, k, {$urandom(), $urandom()}, 1'b0, 0, k, k - 1, 0, 15);
    for (int n = 0; n < 20; n++)
      step(2, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
    // Randomized traffic, small address range to provoke hazards and bypass hits.
    for (int c = 0; c < 3; c++)
      for (int n = 0; n < 150; n++)
        step(c, ($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
             {$urandom(), $urandom()}, ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
